qspi_executor: RTL and testbench
================================

QSPI_EXECUTOR -- requirements
Module: qspi_executor

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 qspi_cmd  input  32  [7:0] opcode; [8] addr_en; [15:12] wlen bytes; [19:16] rlen bytes; other bits ignored.
REQ-005 qspi_addr  input  32  [23:0] flash address, sent MSB-first; [31:24] ignored.
REQ-006 qspi_wdata  input  64  write payload; first byte sent is [63:56].
REQ-007 qspi_start  input  1  single-cycle request strobe.
REQ-008 qspi_idle  output  1  1 = no transaction in progress.
REQ-009 qspi_done  output  1  one-cycle pulse at transaction end.
REQ-010 qspi_rdata  output  64  read result, right-justified; last byte received in [7:0].
REQ-011 spi_sck  output  1  serial clock, mode 0 (idle low).
REQ-012 spi_cs_n  output  1  chip select, active low.
REQ-013 spi_mosi  output  1  serial data out.
REQ-014 spi_miso  input  1  serial data in.

Function
REQ-015 All request inputs SHALL be captured on the cycle qspi_start=1 while in IDLE; later input changes SHALL NOT affect the transaction.
REQ-016 qspi_start asserted while not in IDLE SHALL be ignored (no queuing, no error).
REQ-017 wlen or rlen values above 8 SHALL be clamped to 8.
REQ-018 Bit count N = 8 + 24*addr_en + 8*wlen + 8*rlen; order: opcode, address, write bytes, read bytes, each MSB-first.
REQ-019 States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; no other transitions except reset.
REQ-020 IDLE: cs_n=1, sck=0, mosi=0, qspi_idle=1; start -> SETUP next cycle, cs_n falls, mosi = opcode[7].
REQ-021 SETUP lasts CLK_DIV cycles with sck=0, then -> SHIFT.
REQ-022 SHIFT: per bit, sck low CLK_DIV cycles then high CLK_DIV cycles; miso sampled on the cycle sck goes 0->1; mosi updates on the cycle sck goes 1->0.
REQ-023 During read bytes mosi SHALL be 0.
REQ-024 Each sampled read bit SHALL shift into qspi_rdata[0] with left shift; qspi_rdata SHALL clear to 0 on accepted start.
REQ-025 After bit N's high phase, sck -> 0, enter HOLD for CLK_DIV cycles (cs_n still 0).
REQ-026 GAP: cs_n=1 for CLK_DIV cycles; on exit qspi_idle=1 and qspi_done pulses the same cycle.
REQ-027 cs_n low duration SHALL be exactly 2*CLK_DIV + 2*CLK_DIV*N cycles; sck SHALL show exactly N rising edges per transaction.
REQ-028 qspi_idle SHALL be 0 from the cycle after start is accepted until GAP exits.
REQ-029 qspi_rdata SHALL hold its value from done until the next accepted start.

Reset
REQ-030 On reset: state IDLE, cs_n=1, sck=0, mosi=0, qspi_idle=1, qspi_done=0, qspi_rdata=0, counters 0.
REQ-031 Reset mid-transaction SHALL abort immediately (cs_n high asynchronously), with no done pulse; the next start SHALL run normally.

Verification (CLK_DIV=2 unless stated)
REQ-032 cmd=0x0003_009F (rlen=3), slave model returns 0xEF,0x40,0x18 -> rdata=0x0000_0000_00EF_4018, 32 sck edges, cs_n low 132 cycles, one done pulse.
REQ-033 cmd=0x0000_2102 (addr_en, wlen=2), addr=0x123456, wdata=0xA55A<<48 -> mosi stream 0x02,0x12,0x34,0x56,0xA5,0x5A; rdata=0.
REQ-034 Start pulsed again mid-transaction and inputs changed -> transfer bits unchanged, exactly one done pulse.
REQ-035 rlen=15 -> clamped to 8; 72 sck edges; rdata holds the last 8 bytes received.
REQ-036 Reset asserted during SHIFT -> cs_n=1 and idle=1 immediately, no done pulse; next opcode-only (cmd=0x06) start -> 8 edges, cs_n low 36 cycles.
REQ-037 CLK_DIV=1, opcode-only 0x06 -> sck period 2 cycles, cs_n low 18 cycles, mosi 0x06.

Source files
------------

// File: rtl/qspi_executor.sv
// Single-lane SPI command executor: shifts out opcode/address/write bytes and
// collects read bytes on MISO, SPI mode 0, SCK half-period of CLK_DIV clk cycles.
module qspi_executor #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] qspi_cmd,
    input  logic [31:0] qspi_addr,
    input  logic [63:0] qspi_wdata,
    input  logic        qspi_start,
    output logic        qspi_idle,
    output logic        qspi_done,
    output logic [63:0] qspi_rdata,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned BIT_W = 8;
    localparam int unsigned TX_W  = 96;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BIT_W-1:0]  nbits_q, nbits_d;
    logic [BIT_W-1:0]  rstart_q, rstart_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [63:0]       rdata_d;
    logic              sck_d, cs_n_d, mosi_d, idle_d, done_d;

    // Request decode: clamp lengths, keep only the requested write bytes so
    // the read phase shifts out zeros.
    logic [3:0]        wlen, rlen;
    logic [63:0]       wpay;
    logic [TX_W-1:0]   tx_load;
    logic [BIT_W-1:0]  rstart_load, nbits_load;
    logic              unused_bits;

    assign wlen        = (qspi_cmd[15:12] > 4'd8) ? 4'd8 : qspi_cmd[15:12];
    assign rlen        = (qspi_cmd[19:16] > 4'd8) ? 4'd8 : qspi_cmd[19:16];
    assign wpay        = qspi_wdata & ~(64'hFFFF_FFFF_FFFF_FFFF >> {wlen, 3'b000});
    assign tx_load     = qspi_cmd[8] ? {qspi_cmd[7:0], qspi_addr[23:0], wpay}
                                     : {qspi_cmd[7:0], wpay, 24'd0};
    assign rstart_load = 8'd8 + (qspi_cmd[8] ? 8'd24 : 8'd0) + BIT_W'({wlen, 3'b000});
    assign nbits_load  = rstart_load + BIT_W'({rlen, 3'b000});
    assign unused_bits = ^{qspi_cmd[31:20], qspi_cmd[11:9], qspi_addr[31:24]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            nbits_q    <= '0;
            rstart_q   <= '0;
            tx_q       <= '0;
            qspi_rdata <= '0;
            spi_sck    <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            qspi_idle  <= 1'b1;
            qspi_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            nbits_q    <= nbits_d;
            rstart_q   <= rstart_d;
            tx_q       <= tx_d;
            qspi_rdata <= rdata_d;
            spi_sck    <= sck_d;
            spi_cs_n   <= cs_n_d;
            spi_mosi   <= mosi_d;
            qspi_idle  <= idle_d;
            qspi_done  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        nbits_d  = nbits_q;
        rstart_d = rstart_q;
        tx_d     = tx_q;
        rdata_d  = qspi_rdata;
        sck_d    = spi_sck;
        cs_n_d   = spi_cs_n;
        mosi_d   = spi_mosi;
        idle_d   = qspi_idle;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                idle_d = 1'b1;
                if (qspi_start) begin
                    state_d  = S_SETUP;
                    cnt_d    = '0;
                    bit_d    = '0;
                    nbits_d  = nbits_load;
                    rstart_d = rstart_load;
                    tx_d     = tx_load;
                    mosi_d   = tx_load[TX_W-1];
                    rdata_d  = '0;
                    cs_n_d   = 1'b0;
                    idle_d   = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Rising edge: sample MISO; only bits in the read phase land in rdata.
                if (cnt_q == HALF_LAST) begin
                    sck_d = 1'b1;
                    if (bit_q >= rstart_q) begin
                        rdata_d = {qspi_rdata[62:0], spi_miso};
                    end
                end
                // Falling edge: advance to the next bit or finish.
                if (cnt_q == BIT_LAST) begin
                    sck_d = 1'b0;
                    cnt_d = '0;
                    if (bit_q == BIT_W'(nbits_q - 8'd1)) begin
                        state_d = S_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[TX_W-2];
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    idle_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_qspi_executor.sv
// Bench for qspi_executor: two instances (CLK_DIV=2 and CLK_DIV=1), a SPI slave/monitor,
// and a bit-stream reference model built from the command fields.
module tb_qspi_executor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] cmd_s   [2];
    logic [31:0] addr_s  [2];
    logic [63:0] wdata_s [2];
    logic [1:0]  start_s;
    logic [1:0]  miso_s;
    wire  [1:0]  idle_w, done_w, sck_w, cs_w, mosi_w;
    wire  [63:0] rdata0, rdata1;

    int tests = 0;
    int fails = 0;

    qspi_executor #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .qspi_cmd(cmd_s[0]), .qspi_addr(addr_s[0]),
        .qspi_wdata(wdata_s[0]), .qspi_start(start_s[0]), .qspi_idle(idle_w[0]),
        .qspi_done(done_w[0]), .qspi_rdata(rdata0), .spi_sck(sck_w[0]),
        .spi_cs_n(cs_w[0]), .spi_mosi(mosi_w[0]), .spi_miso(miso_s[0])
    );

    qspi_executor #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .qspi_cmd(cmd_s[1]), .qspi_addr(addr_s[1]),
        .qspi_wdata(wdata_s[1]), .qspi_start(start_s[1]), .qspi_idle(idle_w[1]),
        .qspi_done(done_w[1]), .qspi_rdata(rdata1), .spi_sck(sck_w[1]),
        .spi_cs_n(cs_w[1]), .spi_mosi(mosi_w[1]), .spi_miso(miso_s[1])
    );

    // Slave + monitor: counts cs_n-low cycles, done pulses, SCK rises; captures MOSI
    // on each rise and presents slave bit k before rise k.
    int           rise_cnt [2];
    int           cs_low   [2];
    int           done_cnt [2];
    logic [159:0] mosi_cap [2];
    logic [159:0] slave_vec[2];
    logic         sck_prev [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_w[i] === 1'b0) cs_low[i]++;
            if (done_w[i] === 1'b1) done_cnt[i]++;
            if (sck_w[i] === 1'b1 && sck_prev[i] === 1'b0) begin
                mosi_cap[i] = {mosi_cap[i][158:0], mosi_w[i]};
                rise_cnt[i]++;
            end
            sck_prev[i] = sck_w[i];
            miso_s[i] = (rise_cnt[i] < 160) ? slave_vec[i][159 - rise_cnt[i]] : 1'b0;
        end
    end

    function automatic logic [63:0] rd(input int sel);
        return (sel == 0) ? rdata0 : rdata1;
    endfunction

    task automatic randomize_slave(input int sel);
        slave_vec[sel] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Runs one transaction and checks it against the stream model.
    task automatic run_txn(input int sel, input logic [31:0] cmd, input logic [31:0] addr,
                           input logic [63:0] wdata, input bit disturb, input string name);
        int d, w, r, nb, exp_cs, c;
        bit q[$];
        logic [159:0] exp_s;
        logic [63:0]  exp_rd;
        d = (sel == 0) ? 2 : 1;
        w = int'(cmd[15:12]); if (w > 8) w = 8;
        r = int'(cmd[19:16]); if (r > 8) r = 8;
        for (int i = 7; i >= 0; i--) q.push_back(cmd[i]);
        if (cmd[8]) for (int i = 23; i >= 0; i--) q.push_back(addr[i]);
        for (int i = 0; i < 8 * w; i++) q.push_back(wdata[63 - i]);
        for (int i = 0; i < 8 * r; i++) q.push_back(1'b0);
        nb = q.size();
        exp_s = '0;
        foreach (q[i]) exp_s = {exp_s[158:0], q[i]};
        exp_rd = '0;
        for (int k = nb - 8 * r; k < nb; k++) exp_rd = {exp_rd[62:0], slave_vec[sel][159 - k]};
        exp_cs = 2 * d + 2 * d * nb;

        @(posedge clk); #1;
        rise_cnt[sel] = 0; cs_low[sel] = 0; done_cnt[sel] = 0; mosi_cap[sel] = '0;
        cmd_s[sel] = cmd; addr_s[sel] = addr; wdata_s[sel] = wdata; start_s[sel] = 1'b1;
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        cmd_s[sel] = $urandom; addr_s[sel] = $urandom; wdata_s[sel] = {$urandom, $urandom};
        tests++;
        if (idle_w[sel] !== 1'b0) begin
            fails++; $display("FAIL %s idle_after_start: got %b exp 0", name, idle_w[sel]);
        end
        for (c = 0; c < 4000 && done_cnt[sel] == 0; c++) begin
            @(posedge clk); #1;
            if (disturb && c == 10) begin
                start_s[sel] = 1'b1;
                cmd_s[sel] = $urandom; addr_s[sel] = $urandom; wdata_s[sel] = {$urandom, $urandom};
            end else begin
                start_s[sel] = 1'b0;
            end
        end
        start_s[sel] = 1'b0;
        tests++;
        if (done_cnt[sel] == 0) begin
            fails++; $display("FAIL %s done_timeout: got no done in %0d cycles", name, c);
        end
        repeat (3 * d + 6) begin
            @(posedge clk); #1;
            cmd_s[sel] = $urandom; addr_s[sel] = $urandom; wdata_s[sel] = {$urandom, $urandom};
        end
        tests++;
        if (done_cnt[sel] != 1) begin
            fails++; $display("FAIL %s done_pulses: got %0d exp 1", name, done_cnt[sel]);
        end
        tests++;
        if (rise_cnt[sel] != nb) begin
            fails++; $display("FAIL %s sck_rises: got %0d exp %0d", name, rise_cnt[sel], nb);
        end
        tests++;
        if (cs_low[sel] != exp_cs) begin
            fails++; $display("FAIL %s cs_low_cycles: got %0d exp %0d", name, cs_low[sel], exp_cs);
        end
        tests++;
        if (mosi_cap[sel] !== exp_s) begin
            fails++; $display("FAIL %s mosi_stream: got %h exp %h", name, mosi_cap[sel], exp_s);
        end
        tests++;
        if (rd(sel) !== exp_rd) begin
            fails++; $display("FAIL %s rdata: got %h exp %h", name, rd(sel), exp_rd);
        end
        tests++;
        if (idle_w[sel] !== 1'b1 || cs_w[sel] !== 1'b1 || sck_w[sel] !== 1'b0) begin
            fails++; $display("FAIL %s idle_after_done: got idle=%b cs_n=%b sck=%b exp 1 1 0",
                              name, idle_w[sel], cs_w[sel], sck_w[sel]);
        end
    endtask

    task automatic test_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({idle_w[i], cs_w[i], sck_w[i], mosi_w[i], done_w[i]} !== 5'b11000 || rd(i) !== 64'd0) begin
                fails++;
                $display("FAIL reset_state[%0d]: got idle=%b cs_n=%b sck=%b mosi=%b done=%b rdata=%h exp 1 1 0 0 0 0",
                         i, idle_w[i], cs_w[i], sck_w[i], mosi_w[i], done_w[i], rd(i));
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_jedec_id();
        randomize_slave(0);
        slave_vec[0][151:128] = 24'hEF4018;
        run_txn(0, 32'h0003_009F, 32'h0, 64'h0, 1'b0, "jedec_id");
        tests++;
        if (rdata0 !== 64'h0000_0000_00EF_4018) begin
            fails++; $display("FAIL jedec_id_const: got %h exp 0000000000ef4018", rdata0);
        end
    endtask

    task automatic test_write();
        randomize_slave(0);
        run_txn(0, 32'h0000_2102, 32'h0012_3456, 64'hA55A << 48, 1'b0, "write_addr");
    endtask

    task automatic test_ignore_start();
        randomize_slave(0);
        run_txn(0, 32'h0002_1103, 32'hFF65_4321, {$urandom, $urandom}, 1'b1, "ignore_start");
    endtask

    task automatic test_clamp();
        randomize_slave(0);
        run_txn(0, 32'h000F_000B, 32'h0, 64'h0, 1'b0, "clamp_rlen15");
        randomize_slave(0);
        run_txn(0, 32'h000A_F1AB, $urandom, {$urandom, $urandom}, 1'b0, "clamp_both");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            randomize_slave(0);
            run_txn(0, $urandom, $urandom, {$urandom, $urandom}, 1'b0, "random_div2");
        end
        for (int i = 0; i < 4; i++) begin
            randomize_slave(1);
            run_txn(1, $urandom, $urandom, {$urandom, $urandom}, 1'b0, "random_div1");
        end
    endtask

    task automatic test_abort_reset();
        randomize_slave(0);
        @(posedge clk); #1;
        done_cnt[0] = 0;
        cmd_s[0] = 32'h0003_009F; start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (50) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (cs_w[0] !== 1'b1 || idle_w[0] !== 1'b1 || sck_w[0] !== 1'b0 || rdata0 !== 64'd0) begin
            fails++; $display("FAIL abort_async: got cs_n=%b idle=%b sck=%b rdata=%h exp 1 1 0 0",
                              cs_w[0], idle_w[0], sck_w[0], rdata0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (done_cnt[0] != 0) begin
            fails++; $display("FAIL abort_no_done: got %0d exp 0", done_cnt[0]);
        end
        randomize_slave(0);
        run_txn(0, 32'h0000_0006, 32'h0, 64'h0, 1'b0, "after_abort");
    endtask

    task automatic test_clk_div1();
        randomize_slave(1);
        run_txn(1, 32'h0000_0006, 32'h0, 64'h0, 1'b0, "div1_opcode");
    endtask

    initial begin
        reset = 1'b1;
        start_s = '0;
        for (int i = 0; i < 2; i++) begin
            cmd_s[i] = '0; addr_s[i] = '0; wdata_s[i] = '0;
            slave_vec[i] = '0; mosi_cap[i] = '0;
            rise_cnt[i] = 0; cs_low[i] = 0; done_cnt[i] = 0;
        end
        test_reset();
        test_jedec_id();
        test_write();
        test_ignore_start();
        test_clamp();
        test_abort_reset();
        test_clk_div1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
